tone_sequencer: RTL and testbench

- Upstream stage of the ROM-controlled frequency divider; produces the 5-bit `F_select` code that the divider consumes.
- Steps through an internal pattern table: each step is a divider code plus a duration in ticks.
- Plays once or loops, with start/stop/pause control, so a melody or sweep runs without external stepping logic.
- Code 0 means silence.

---
 rtl/tone_sequencer_if.sv | 38 +++
 rtl/tone_sequencer.sv | 163 ++++++++++++++++
 tb/tb_tone_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/tone_sequencer_if.sv
// rtl/tone_sequencer_if.sv - control/status bundle between the tone sequencer and its controller
// Optional table-write signals exist only when TONE_SEQ_WRITE_EN is defined.
interface tone_sequencer_if #(
    parameter int STEPS = 16
);
    logic                     start;
    logic                     stop;
    logic                     pause;
    logic                     loop;
    logic [4:0]               F_select;
    logic                     busy;
    logic [$clog2(STEPS)-1:0] step_idx;
    logic                     step_strobe;
    logic                     done;
`ifdef TONE_SEQ_WRITE_EN
    logic                     wr_en;
    logic [$clog2(STEPS)-1:0] wr_addr;
    logic [7:0]               wr_data;

    modport master (
        output start, stop, pause, loop, wr_en, wr_addr, wr_data,
        input  F_select, busy, step_idx, step_strobe, done
    );
    modport slave (
        input  start, stop, pause, loop, wr_en, wr_addr, wr_data,
        output F_select, busy, step_idx, step_strobe, done
    );
`else
    modport master (
        output start, stop, pause, loop,
        input  F_select, busy, step_idx, step_strobe, done
    );
    modport slave (
        input  start, stop, pause, loop,
        output F_select, busy, step_idx, step_strobe, done
    );
`endif
endinterface

// File: rtl/tone_sequencer.sv
// rtl/tone_sequencer.sv - steps a code/duration pattern table to drive a divider F_select
// Macro TONE_SEQ_WRITE_EN turns the constant table into a writable register array.
module tone_sequencer #(
    parameter int TICK_DIV = 1000,
    parameter int STEPS    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    tone_sequencer_if.slave   bus
);
    localparam int IW = $clog2(STEPS);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, PLAY, PAUSE} state_t;

    // Entry layout {code[4:0], dur[1:0]}
    function automatic logic [6:0] hw_entry(input int i);
        logic [4:0] code;
        code = 5'((i % 31) + 1);
        return {code, 2'(i)};
    endfunction

    state_t        r_state, w_state_nxt;
    logic [PW-1:0] r_pre, w_pre_nxt;
    logic [2:0]    r_rem, w_rem_nxt;
    logic [IW-1:0] r_idx, w_idx_nxt;
    logic [4:0]    r_fsel, w_fsel_nxt;
    logic [4:0]    r_code, w_code_nxt;
    logic          r_strobe, w_strobe_nxt;
    logic          r_done, w_done_nxt;
    logic          w_run;
    logic [IW-1:0] w_load_idx;
    logic [6:0]    w_load_entry;

    assign w_load_idx = (r_state == IDLE) ? '0 : r_idx + 1'b1;

`ifdef TONE_SEQ_WRITE_EN
    logic [6:0] r_pattern [STEPS];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < STEPS; i++) r_pattern[i] <= hw_entry(i);
        end else if (bus.wr_en) begin
            r_pattern[bus.wr_addr] <= {bus.wr_data[7:3], bus.wr_data[1:0]};
        end
    end

    assign w_load_entry = r_pattern[w_load_idx];
`else
    assign w_load_entry = hw_entry(int'(w_load_idx));
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_pre    <= '0;
            r_rem    <= '0;
            r_idx    <= '0;
            r_fsel   <= '0;
            r_code   <= '0;
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pre    <= w_pre_nxt;
            r_rem    <= w_rem_nxt;
            r_idx    <= w_idx_nxt;
            r_fsel   <= w_fsel_nxt;
            r_code   <= w_code_nxt;
            r_strobe <= w_strobe_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pre_nxt    = r_pre;
        w_rem_nxt    = r_rem;
        w_idx_nxt    = r_idx;
        w_fsel_nxt   = r_fsel;
        w_code_nxt   = r_code;
        w_strobe_nxt = 1'b0;
        w_done_nxt   = 1'b0;
        w_run        = 1'b0;

        case (r_state)
            IDLE: begin
                w_fsel_nxt = '0;
                if (bus.start && !bus.stop) begin
                    w_state_nxt  = PLAY;
                    w_idx_nxt    = '0;
                    w_fsel_nxt   = w_load_entry[6:2];
                    w_code_nxt   = w_load_entry[6:2];
                    w_strobe_nxt = 1'b1;
                    w_pre_nxt    = '0;
                    w_rem_nxt    = {1'b0, w_load_entry[1:0]} + 3'd1;
                end
            end
            PLAY: begin
                if (bus.stop) begin
                    w_state_nxt = IDLE;
                end else if (bus.pause) begin
                    // Entering pause swallows this edge's count, including a coincident tick
                    w_state_nxt = PAUSE;
                    w_fsel_nxt  = '0;
                end else begin
                    w_run = 1'b1;
                end
            end
            PAUSE: begin
                if (bus.stop) begin
                    w_state_nxt = IDLE;
                end else if (!bus.pause) begin
                    // The resume edge counts so the hold grows by exactly the paused cycles
                    w_state_nxt = PLAY;
                    w_fsel_nxt  = r_code;
                    w_run       = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_state_nxt == IDLE && r_state != IDLE) begin
            w_fsel_nxt = '0;
            w_idx_nxt  = '0;
            w_pre_nxt  = '0;
            w_rem_nxt  = '0;
        end

        if (w_run) begin
            if (r_pre == PRE_MAX) begin
                w_pre_nxt = '0;
                if (r_rem == 3'd1) begin
                    if (r_idx == LAST_IDX && !bus.loop) begin
                        w_state_nxt = IDLE;
                        w_fsel_nxt  = '0;
                        w_idx_nxt   = '0;
                        w_rem_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_idx_nxt    = w_load_idx;
                        w_fsel_nxt   = w_load_entry[6:2];
                        w_code_nxt   = w_load_entry[6:2];
                        w_rem_nxt    = {1'b0, w_load_entry[1:0]} + 3'd1;
                        w_strobe_nxt = 1'b1;
                    end
                end else begin
                    w_rem_nxt = r_rem - 3'd1;
                end
            end else begin
                w_pre_nxt = r_pre + 1'b1;
            end
        end
    end

    assign bus.F_select    = r_fsel;
    assign bus.busy        = (r_state != IDLE);
    assign bus.step_idx    = r_idx;
    assign bus.step_strobe = r_strobe;
    assign bus.done        = r_done;
endmodule

// File: tb/tb_tone_sequencer.sv
// tb/tb_tone_sequencer.sv - scoreboard bench for tone_sequencer (TICK_DIV=4, STEPS=4)
module tb_tone_sequencer;
    localparam int TICK_DIV = 4;
    localparam int STEPS    = 4;

    typedef struct {
        int cyc;
        int is_done;
        int fsel;
        int idx;
        int busy;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    ev_t  sb[$];

    tone_sequencer_if #(.STEPS(STEPS)) bus ();

    tone_sequencer #(.TICK_DIV(TICK_DIV), .STEPS(STEPS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int c, input int d, input int f, input int i, input int b);
        ev_t e;
        e.cyc = c; e.is_done = d; e.fsel = f; e.idx = i; e.busy = b;
        sb.push_back(e);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic check_idle(input string name);
        check({name, "_fsel"}, int'(bus.F_select), 0);
        check({name, "_busy"}, int'(bus.busy), 0);
        check({name, "_idx"}, int'(bus.step_idx), 0);
    endtask

    // Monitor: every strobe/done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (bus.step_strobe || bus.done) begin
            check("strobe_done_exclusive", int'(bus.step_strobe && bus.done), 0);
            if (sb.size() == 0) begin
                check("unexpected_event", 1, 0);
            end else begin
                ev_t e;
                e = sb.pop_front();
                check("ev_kind", int'(bus.done), e.is_done);
                check("ev_cycle", cyc, e.cyc);
                check("ev_fsel", int'(bus.F_select), e.fsel);
                check("ev_idx", int'(bus.step_idx), e.idx);
                check("ev_busy", int'(bus.busy), e.busy);
            end
        end
    end

    initial begin
        int e;
        bus.start = 1'b1;
        bus.stop  = 1'b0;
        bus.pause = 1'b0;
        bus.loop  = 1'b0;
`ifdef TONE_SEQ_WRITE_EN
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
`endif
        // Reset with start held high: start must be ignored
        repeat (3) @(negedge clk);
        check_idle("reset");
        check("reset_strobe", int'(bus.step_strobe), 0);
        check("reset_done", int'(bus.done), 0);
        reset_n   = 1'b1;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);

        // Single pass, loop=0
        e = cyc + 1;
        push_ev(e, 0, 1, 0, 1);
        push_ev(e + 4, 0, 2, 1, 1);
        push_ev(e + 12, 0, 3, 2, 1);
        push_ev(e + 24, 0, 4, 3, 1);
        push_ev(e + 40, 1, 0, 0, 0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_to(e + 2);
        check("play_fsel_step0", int'(bus.F_select), 1);
        check("play_busy", int'(bus.busy), 1);
        wait_to(e + 30);
        check("play_fsel_step3", int'(bus.F_select), 4);
        wait_to(e + 44);
        check_idle("after_done");

        // Looping pass with an ignored start pulse, then stop
        bus.loop = 1'b1;
        e = cyc + 1;
        push_ev(e, 0, 1, 0, 1);
        push_ev(e + 4, 0, 2, 1, 1);
        push_ev(e + 12, 0, 3, 2, 1);
        push_ev(e + 24, 0, 4, 3, 1);
        push_ev(e + 40, 0, 1, 0, 1);
        push_ev(e + 44, 0, 2, 1, 1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_to(e + 6);
        bus.start = 1'b1;
        wait_to(e + 7);
        bus.start = 1'b0;
        wait_to(e + 42);
        check("loop_busy", int'(bus.busy), 1);
        wait_to(e + 46);
        bus.stop = 1'b1;
        wait_to(e + 47);
        bus.stop = 1'b0;
        bus.loop = 1'b0;
        check_idle("after_stop");
        wait_to(e + 52);

        // start and stop together in IDLE
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check_idle("start_stop_idle");
        repeat (2) @(negedge clk);

        // Pause for 10 cycles inside step 1
        e = cyc + 1;
        push_ev(e, 0, 1, 0, 1);
        push_ev(e + 4, 0, 2, 1, 1);
        push_ev(e + 22, 0, 3, 2, 1);
        push_ev(e + 34, 0, 4, 3, 1);
        push_ev(e + 50, 1, 0, 0, 0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_to(e + 5);
        bus.pause = 1'b1;
        for (int t = e + 6; t <= e + 15; t++) begin
            wait_to(t);
            check("pause_fsel", int'(bus.F_select), 0);
            check("pause_busy", int'(bus.busy), 1);
            check("pause_idx", int'(bus.step_idx), 1);
        end
        bus.pause = 1'b0;
        wait_to(e + 16);
        check("resume_fsel", int'(bus.F_select), 2);
        wait_to(e + 53);

        // Reset mid-play with start held
        e = cyc + 1;
        push_ev(e, 0, 1, 0, 1);
        push_ev(e + 4, 0, 2, 1, 1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_to(e + 5);
        reset_n   = 1'b0;
        bus.start = 1'b1;
        wait_to(e + 6);
        reset_n   = 1'b1;
        bus.start = 1'b0;
        check_idle("midplay_reset");
        check("midplay_reset_strobe", int'(bus.step_strobe), 0);
        wait_to(e + 20);
        check("midplay_reset_stays_idle", int'(bus.busy), 0);

`ifdef TONE_SEQ_WRITE_EN
        // Rewrite step 2 while idle, then play it
        bus.wr_en   = 1'b1;
        bus.wr_addr = 2'd2;
        bus.wr_data = {5'd20, 3'd0};
        @(negedge clk);
        bus.wr_en = 1'b0;
        e = cyc + 1;
        push_ev(e, 0, 1, 0, 1);
        push_ev(e + 4, 0, 2, 1, 1);
        push_ev(e + 12, 0, 20, 2, 1);
        push_ev(e + 16, 0, 4, 3, 1);
        push_ev(e + 32, 1, 0, 0, 0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_to(e + 14);
        check("wr_fsel_step2", int'(bus.F_select), 20);
        wait_to(e + 36);
`endif

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
